// File: rtl/regfile_write_arbiter_if.sv
// Bundles the two writeback requesters, the register-file write port and the
// arbiter status outputs between the requester side (master) and the arbiter (slave).
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
);
   logic              hold;
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic [ADDR_W-1:0] rf_rd;
   logic [DATA_W-1:0] rf_wd;
   logic              rf_we;
   logic              last_grant;
   logic [CNT_W-1:0]  conflict_cnt;

   modport master (
      output hold, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready, rf_rd, rf_wd, rf_we, last_grant, conflict_cnt
   );

   modport slave (
      input  hold, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready, rf_rd, rf_wd, rf_we, last_grant, conflict_cnt
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and
// load writeback paths; registered RD/WD/we, r0 write suppression, conflict counter.
module regfile_write_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 8
) (
   input logic                   clk,
   input logic                   reset,
   regfile_write_arbiter_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              grant0, grant1, grant_any, contested;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] wd_q;
   logic              we_q;
   logic              last_q;
   logic [CNT_W-1:0]  cnt_q;

   // last_q==1 means req1 won last, so req0 wins a contest; readies are forced low in reset
   always_comb begin
      contested = bus.req0_valid && bus.req1_valid && !bus.hold;
      grant0    = 1'b0;
      grant1    = 1'b0;
      if (!reset && !bus.hold) begin
         if (bus.req0_valid && bus.req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
         end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
         end
      end
      grant_any = grant0 || grant1;
      sel_addr  = grant1 ? bus.req1_addr : bus.req0_addr;
      sel_data  = grant1 ? bus.req1_data : bus.req0_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q   <= '0;
         wd_q   <= '0;
         we_q   <= 1'b0;
         last_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         we_q <= 1'b0;
         if (grant_any) begin
            rd_q   <= sel_addr;
            wd_q   <= sel_data;
            // register 0 is hardwired; the handshake still completes
            we_q   <= (sel_addr != '0);
            last_q <= grant1;
         end
         if (contested && cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.req0_ready   = grant0;
   assign bus.req1_ready   = grant1;
   assign bus.rf_rd        = rd_q;
   assign bus.rf_wd        = wd_q;
   assign bus.rf_we        = we_q;
   assign bus.last_grant   = last_q;
   assign bus.conflict_cnt = cnt_q;
endmodule
